// File: rtl/iicc_link_ctrl.sv
// Inter-chassis GT link bring-up/supervision: GT reset sequencing, periodic
// comma hunt and lock, then framing/error-rate monitoring with automatic retrain.
module iicc_link_ctrl #(
  parameter int DWIDTH       = 32,
  parameter int COMMA_PERIOD = 16,
  parameter int RST_CYCLES   = 64,
  parameter int DONE_TIMEOUT = 65535,
  parameter int HUNT_TIMEOUT = 4096,
  parameter int LOCK_COUNT   = 8,
  parameter int MISS_MAX     = 4,
  parameter int ERR_WINDOW   = 1024,
  parameter int ERR_MAX      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  resetdone,
  input  logic [DWIDTH/8-1:0]   rxcharisk,
  input  logic [DWIDTH/8-1:0]   rxdisperr,
  input  logic [DWIDTH/8-1:0]   rxnotintable,
  input  logic                  force_retrain,
  output logic                  gt_reset,
  output logic                  rxuserrdy,
  output logic                  link_up,
  output logic [2:0]            state,
  output logic [15:0]           retrain_cnt,
  output logic [15:0]           err_cnt
);
  localparam int PW = $clog2(COMMA_PERIOD);
  localparam int CW = $clog2(((RST_CYCLES > DONE_TIMEOUT) ? RST_CYCLES : DONE_TIMEOUT) + 1);
  localparam int HW = $clog2(HUNT_TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam int WW = $clog2(ERR_WINDOW + 1);
  localparam int EW = $clog2(ERR_MAX + 1);

  typedef enum logic [2:0] {
    S_RESET = 3'd0, S_WAIT_DONE = 3'd1, S_HUNT = 3'd2,
    S_ALIGN = 3'd3, S_UP = 3'd4, S_RETRAIN = 3'd5
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cyc_reg;
  logic [HW-1:0]  hunt_reg;
  logic [PW-1:0]  pcnt_reg, pcnt_next;
  logic [GW-1:0]  good_reg, good_next;
  logic [MW-1:0]  miss_reg, miss_next;
  logic [WW-1:0]  win_cnt_reg;
  logic [EW-1:0]  win_err_reg;
  logic [15:0]    retrain_cnt_reg, err_cnt_reg;
  logic           gt_reset_reg, rxuserrdy_reg, link_up_reg;

  logic comma, partial, cerr, due, off_slot;
  assign comma    = &rxcharisk;
  assign partial  = (|rxcharisk) & ~comma;
  assign cerr     = |(rxdisperr | rxnotintable);
  assign due      = (pcnt_reg == '0);
  // Any slot that breaks the comma cadence: missing at due, or K seen early.
  assign off_slot = (due & ~comma) | (~due & (comma | partial));

  always_comb begin
    state_next = state_reg;
    pcnt_next  = pcnt_reg + PW'(1);
    good_next  = '0;
    miss_next  = '0;
    case (state_reg)
      S_RESET: begin
        pcnt_next = '0;
        if (cyc_reg == CW'(RST_CYCLES - 1)) state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        pcnt_next = '0;
        if (resetdone) state_next = S_HUNT;
        else if (cyc_reg == CW'(DONE_TIMEOUT - 1)) state_next = S_RESET;
      end
      S_HUNT: begin
        if (comma) begin
          pcnt_next  = PW'(1);
          good_next  = GW'(1);
          state_next = S_ALIGN;
        end
      end
      S_ALIGN: begin
        good_next = good_reg;
        if (due && comma) begin
          pcnt_next = PW'(1);
          good_next = good_reg + GW'(1);
          if (good_reg + GW'(1) == GW'(LOCK_COUNT)) state_next = S_UP;
        end else if (off_slot) begin
          if (comma) begin
            pcnt_next = PW'(1);
            good_next = GW'(1);
          end else begin
            state_next = S_HUNT;
          end
        end
      end
      S_UP: begin
        miss_next = miss_reg;
        if (due && comma) begin
          pcnt_next = PW'(1);
          miss_next = '0;
        end else if (off_slot) begin
          miss_next = miss_reg + MW'(1);
          if (miss_reg + MW'(1) == MW'(MISS_MAX)) state_next = S_RETRAIN;
        end
        if (cerr && (win_err_reg + EW'(1) >= EW'(ERR_MAX))) state_next = S_RETRAIN;
      end
      default: begin
        pcnt_next  = '0;
        state_next = S_RESET;
      end
    endcase
    if ((state_reg == S_HUNT || state_reg == S_ALIGN) && hunt_reg == HW'(HUNT_TIMEOUT - 1))
      state_next = S_RETRAIN;
    if (force_retrain && state_reg != S_RESET && state_reg != S_RETRAIN)
      state_next = S_RETRAIN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= S_RESET;
      cyc_reg         <= '0;
      hunt_reg        <= '0;
      pcnt_reg        <= '0;
      good_reg        <= '0;
      miss_reg        <= '0;
      win_cnt_reg     <= '0;
      win_err_reg     <= '0;
      retrain_cnt_reg <= '0;
      err_cnt_reg     <= '0;
      gt_reset_reg    <= 1'b1;
      rxuserrdy_reg   <= 1'b0;
      link_up_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= (state_next != state_reg) ? '0 : cyc_reg + CW'(1);
      hunt_reg  <= (state_reg == S_HUNT || state_reg == S_ALIGN) ? hunt_reg + HW'(1) : '0;
      pcnt_reg  <= pcnt_next;
      good_reg  <= good_next;
      miss_reg  <= miss_next;
      // Error-rate window runs only while UP and restarts on every UP entry.
      if (state_reg == S_UP) begin
        if (win_cnt_reg == WW'(ERR_WINDOW - 1)) begin
          win_cnt_reg <= '0;
          win_err_reg <= '0;
        end else begin
          win_cnt_reg <= win_cnt_reg + WW'(1);
          win_err_reg <= win_err_reg + EW'(cerr);
        end
        if (cerr && err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
      end else begin
        win_cnt_reg <= '0;
        win_err_reg <= '0;
      end
      if (state_next == S_RETRAIN && state_reg != S_RETRAIN && retrain_cnt_reg != 16'hFFFF)
        retrain_cnt_reg <= retrain_cnt_reg + 16'd1;
      gt_reset_reg  <= (state_next == S_RESET);
      rxuserrdy_reg <= (state_next == S_HUNT) || (state_next == S_ALIGN) || (state_next == S_UP);
      link_up_reg   <= (state_next == S_UP);
    end
  end

  assign state       = state_reg;
  assign gt_reset    = gt_reset_reg;
  assign rxuserrdy   = rxuserrdy_reg;
  assign link_up     = link_up_reg;
  assign retrain_cnt = retrain_cnt_reg;
  assign err_cnt     = err_cnt_reg;
endmodule

// File: doc/iicc_link_ctrl.md
Name: iicc_link_ctrl

Overview:
- Bring-up and supervision controller for the inter-chassis GT link.
- Sequences GT reset and resetdone, hunts the periodic comma (K28.5 0xbc, all bytes K, one word every COMMA_PERIOD cycles), and declares link_up after LOCK_COUNT on-time commas.
- Monitors disparity/not-in-table errors and comma timing while up; retrains automatically on loss.
- Sits in the rx user-clock domain between the GT wrapper and the ICC data path.

Parameters:
- DWIDTH, 32, GT data width; DBYTE=DWIDTH/8 derived.
- COMMA_PERIOD, 16, cycles between commas (power of 2, >=4).
- RST_CYCLES, 64, cycles gt_reset held high.
- DONE_TIMEOUT, 65535, max cycles waiting for resetdone.
- HUNT_TIMEOUT, 4096, max cycles in HUNT/ALIGN before retrain.
- LOCK_COUNT, 8, consecutive on-time commas to declare up.
- MISS_MAX, 4, consecutive bad comma slots in UP before retrain.
- ERR_WINDOW, 1024, error-rate window length in cycles.
- ERR_MAX, 16, code errors within one window that force retrain.

Ports:
- clk, input, 1, GT rx user clock.
- rst_n, input, 1, synchronous active-low reset.
- resetdone, input, 1, GT reset complete.
- rxcharisk, input, DBYTE, per-byte K flag.
- rxdisperr, input, DBYTE, per-byte disparity error.
- rxnotintable, input, DBYTE, per-byte not-in-table error.
- force_retrain, input, 1, one-cycle request to retrain.
- gt_reset, output, 1, GT reset.
- rxuserrdy, output, 1, rx user ready to GT.
- link_up, output, 1, link aligned and healthy.
- state, output, 3, current FSM state encoding.
- retrain_cnt, output, 16, saturating count of retrains.
- err_cnt, output, 16, saturating count of code-error cycles while UP.

Behaviour:
- All outputs registered. Sampled when rst_n=0 at a clk edge:
  - state=RESET(0), gt_reset=1, rxuserrdy=0, link_up=0.
  - retrain_cnt=0, err_cnt=0, all internal counters 0.
- Decodes:
  - comma = &rxcharisk.
  - partial = |rxcharisk & ~comma (treated as bad slot).
  - cerr = |(rxdisperr|rxnotintable).
- Phase counter pcnt (log2 COMMA_PERIOD bits):
  - Loads 1 on an accepted comma, otherwise increments with wrap.
  - Comma slot is due when pcnt==0, i.e. exactly COMMA_PERIOD cycles after the previous comma.
- States:
  - RESET(0): gt_reset=1, link_up=0, rxuserrdy=0. After RST_CYCLES cycles, go to WAIT_DONE.
  - WAIT_DONE(1): gt_reset=0. When resetdone=1, set rxuserrdy=1 and go to HUNT. If DONE_TIMEOUT cycles elapse first, go to RESET.
  - HUNT(2): on the first comma, load pcnt=1, set good=1, go to ALIGN.
  - ALIGN(3):
    - Due slot with comma: good++.
    - Due slot without comma, or comma/partial at a non-due slot: if the cycle is a comma, restart with good=1 and pcnt=1, else go to HUNT.
    - When good reaches LOCK_COUNT, go to UP, with link_up=1 on the following cycle.
  - UP(4):
    - Due slot with comma clears miss.
    - Due slot without comma, or early comma/partial, increments miss; an early comma does not realign pcnt.
    - miss==MISS_MAX leads to RETRAIN.
    - Each cerr cycle increments both the window error counter and err_cnt (saturating at 0xFFFF).
    - Window counter restarts every ERR_WINDOW cycles; reaching ERR_MAX errors within a window leads to RETRAIN.
  - RETRAIN(5): single cycle. link_up=0, rxuserrdy=0, retrain_cnt++ (saturating), go to RESET.
- HUNT_TIMEOUT counts cycles spent in HUNT+ALIGN; expiry leads to RETRAIN.
- force_retrain=1 in any state except RESET/RETRAIN goes to RETRAIN next cycle and overrides all other transitions.
- link_up drops in the same cycle the FSM leaves UP (registered from next state).
- Simultaneous events in UP (miss limit, error limit, force) are counted once: one RETRAIN, retrain_cnt+1.
- Reset mid-operation aborts immediately to RESET and does not increment retrain_cnt.
- rxcharisk and the error inputs are ignored in RESET and WAIT_DONE.

Test Plan:
- Clean bring-up: assert resetdone 10 cycles after gt_reset falls; send comma every 16 cycles → gt_reset high for exactly 64 cycles, link_up=1 one cycle after the 8th comma, retrain_cnt=0.
- Early comma in ALIGN: 4 good commas, then a comma at 12-cycle spacing → good restarts at 1; link_up only after 8 further commas at 16-cycle spacing from that comma.
- Loss of framing in UP: drop 4 consecutive commas → RETRAIN, link_up=0, retrain_cnt=1, gt_reset reasserted next cycle. Drop only 3 then resume → link_up stays 1, miss cleared.
- Error rate: inject cerr 15 times in one 1024-cycle window → stay UP, err_cnt=15. A 16th in the same window → retrain, retrain_cnt=1, err_cnt=16.
- Timeouts: resetdone never rises → back to RESET after 65535 cycles. No comma after resetdone → RETRAIN after 4096 cycles.
- force_retrain pulsed in UP on the same cycle as the 4th miss → exactly one retrain (retrain_cnt +1). rst_n low for one cycle while UP → all outputs at reset values, retrain_cnt=0.
